// File: rtl/cla_8b_if.sv
// Operand/result bundle for the 8-bit carry-lookahead adder.
// The master drives operands and carry-in; the slave (the adder) drives results.
interface cla_8b_if;
    logic [7:0]  A;
    logic [7:0]  B;
    logic        cin;
    logic [15:0] sum;
    logic [15:0] sum_r;
    logic        cout;
    logic        P;
    logic        G;

    modport master (
        output A,
        output B,
        output cin,
        input  sum,
        input  sum_r,
        input  cout,
        input  P,
        input  G
    );

    modport slave (
        input  A,
        input  B,
        input  cin,
        output sum,
        output sum_r,
        output cout,
        output P,
        output G
    );
endinterface

// File: rtl/cla_8b.sv
// 8-bit carry-lookahead adder: two 4-bit lookahead groups joined by a
// second-level lookahead unit, so no carry ripples through all eight bits.
// sum/cout/P/G are purely combinational; sum_r is the only state.
module cla_8b (
    input  logic     clk,
    input  logic     rst_n,
    cla_8b_if.slave  bus
);

    // Carries into the four bits of a group (index 0 is the group carry-in),
    // each one a flat sum-of-products of the group's p/g and carry-in.
    function automatic logic [3:0] group_carries(
        input logic [3:0] p4,
        input logic [3:0] g4,
        input logic       ci
    );
        logic [3:0] c;
        c[0] = ci;
        c[1] = g4[0] | (p4[0] & ci);
        c[2] = g4[1] | (p4[1] & g4[0]) | (p4[1] & p4[0] & ci);
        c[3] = g4[2] | (p4[2] & g4[1]) | (p4[2] & p4[1] & g4[0])
             | (p4[2] & p4[1] & p4[0] & ci);
        return c;
    endfunction

    // Group generate: carry leaving the group when its carry-in is 0.
    function automatic logic group_generate(
        input logic [3:0] p4,
        input logic [3:0] g4
    );
        return g4[3] | (p4[3] & g4[2]) | (p4[3] & p4[2] & g4[1])
             | (p4[3] & p4[2] & p4[1] & g4[0]);
    endfunction

    logic [7:0]  p;
    logic [7:0]  g;
    logic [7:0]  c;
    logic [7:0]  s;
    logic        p0_grp;
    logic        g0_grp;
    logic        p1_grp;
    logic        g1_grp;
    logic        c4;
    logic        c8;
    logic [15:0] sum_d;
    logic [15:0] sum_r_q;

    // Per-bit propagate and generate terms.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_bit_pg
            assign p[gi] = bus.A[gi] ^ bus.B[gi];
            assign g[gi] = bus.A[gi] & bus.B[gi];
        end
    endgenerate

    // Group propagate/generate for the low (3:0) and high (7:4) nibbles.
    assign p0_grp = &p[3:0];
    assign g0_grp = group_generate(p[3:0], g[3:0]);
    assign p1_grp = &p[7:4];
    assign g1_grp = group_generate(p[7:4], g[7:4]);

    // Second-level unit: c4 and c8 come straight from group terms and cin,
    // never from the bit-3 or bit-7 carry of a group.
    assign c4 = g0_grp | (p0_grp & bus.cin);
    assign c8 = g1_grp | (p1_grp & g0_grp) | (p1_grp & p0_grp & bus.cin);

    assign c[3:0] = group_carries(p[3:0], g[3:0], bus.cin);
    assign c[7:4] = group_carries(p[7:4], g[7:4], c4);

    // Sum bits are the bit propagate XOR the incoming carry.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_sum_bit
            assign s[gi] = p[gi] ^ c[gi];
        end
    endgenerate

    // Exact result is at most 0x1FF, so bits 15:9 are always zero.
    assign sum_d = {7'b0, c8, s};

    // Registered copy for pipelined consumers; reset clears it immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r_q <= 16'h0000;
        end else begin
            sum_r_q <= sum_d;
        end
    end

    assign bus.sum   = sum_d;
    assign bus.sum_r = sum_r_q;
    assign bus.cout  = c8;
    assign bus.P     = p1_grp & p0_grp;
    assign bus.G     = g1_grp | (p1_grp & g0_grp);

endmodule

// File: tb/tb_cla_8b.sv
// Scoreboard bench for cla_8b: stimulus pushes expected results into a queue
// and signals the monitor, which pops and compares against the DUT outputs.
module tb_cla_8b;

    typedef struct {
        bit          is_reg;   // 1: compare sum_r, 0: compare sum/cout/P/G
        string       name;
        logic [7:0]  a;
        logic [7:0]  b;
        logic        ci;
        logic [15:0] exp_val;
        logic        exp_cout;
        logic        exp_p;
        logic        exp_g;
    } exp_t;

    logic clk;
    logic rst_n;
    cla_8b_if bus_if ();

    cla_8b dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    exp_t expq[$];
    event sample_ev;
    int   checks;
    int   errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: on every sample point drain the scoreboard and compare.
    initial begin
        exp_t e;
        forever begin
            @(sample_ev);
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty: sample with no expectation queued");
            end
            while (expq.size() > 0) begin
                e = expq.pop_front();
                if (e.is_reg) begin
                    checks++;
                    if (bus_if.sum_r !== e.exp_val) begin
                        errors++;
                        $display("FAIL %s sum_r: got %h expected %h", e.name, bus_if.sum_r, e.exp_val);
                    end else
                        $display("check %s sum_r=%h ok", e.name, bus_if.sum_r);
                end else begin
                    checks += 4;
                    if (bus_if.sum !== e.exp_val) begin
                        errors++;
                        $display("FAIL %s sum A=%h B=%h cin=%b: got %h expected %h",
                                 e.name, e.a, e.b, e.ci, bus_if.sum, e.exp_val);
                    end
                    if (bus_if.cout !== e.exp_cout) begin
                        errors++;
                        $display("FAIL %s cout A=%h B=%h cin=%b: got %b expected %b",
                                 e.name, e.a, e.b, e.ci, bus_if.cout, e.exp_cout);
                    end
                    if (bus_if.P !== e.exp_p) begin
                        errors++;
                        $display("FAIL %s P A=%h B=%h cin=%b: got %b expected %b",
                                 e.name, e.a, e.b, e.ci, bus_if.P, e.exp_p);
                    end
                    if (bus_if.G !== e.exp_g) begin
                        errors++;
                        $display("FAIL %s G A=%h B=%h cin=%b: got %b expected %b",
                                 e.name, e.a, e.b, e.ci, bus_if.G, e.exp_g);
                    end
                    if (e.name != "sweep")
                        $display("check %s A=%h B=%h cin=%b sum=%h cout=%b P=%b G=%b",
                                 e.name, e.a, e.b, e.ci, bus_if.sum, bus_if.cout, bus_if.P, bus_if.G);
                end
            end
        end
    end

    // Queue a combinational expectation for the given operands.
    task automatic push_comb(input string name, input logic [7:0] a, input logic [7:0] b,
                             input logic ci, input logic [15:0] es, input logic ec,
                             input logic ep, input logic eg);
        exp_t e;
        e.is_reg = 1'b0; e.name = name; e.a = a; e.b = b; e.ci = ci;
        e.exp_val = es; e.exp_cout = ec; e.exp_p = ep; e.exp_g = eg;
        expq.push_back(e);
    endtask

    task automatic push_reg(input string name, input logic [15:0] ev);
        exp_t e;
        e.is_reg = 1'b1; e.name = name; e.a = '0; e.b = '0; e.ci = 1'b0;
        e.exp_val = ev; e.exp_cout = 1'b0; e.exp_p = 1'b0; e.exp_g = 1'b0;
        expq.push_back(e);
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic ci);
        bus_if.A   = a;
        bus_if.B   = b;
        bus_if.cin = ci;
    endtask

    // Apply operands, queue the expectation, and sample 1 time unit later.
    task automatic vec(input string name, input logic [7:0] a, input logic [7:0] b,
                       input logic ci, input logic [15:0] es, input logic ec,
                       input logic ep, input logic eg);
        drive(a, b, ci);
        push_comb(name, a, b, ci, es, ec, ep, eg);
        #1;
        -> sample_ev;
        #1;
    endtask

    initial begin
        logic [15:0] es;
        logic [7:0]  av;
        logic [7:0]  bv;
        checks = 0;
        errors = 0;
        rst_n  = 1'b1;
        drive(8'h00, 8'h00, 1'b0);
        #2;

        // Directed carry/propagate vectors with hand-computed results.
        //   name             A      B     cin  sum       cout  P     G
        vec("carry_ff_01",  8'hFF, 8'h01, 1'b0, 16'h0100, 1'b1, 1'b0, 1'b1);
        vec("grp0_to_grp1", 8'h0F, 8'h01, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b0);
        vec("max_ff_ff_c1", 8'hFF, 8'hFF, 1'b1, 16'h01FF, 1'b1, 1'b0, 1'b1);
        vec("prop_aa_55",   8'hAA, 8'h55, 1'b1, 16'h0100, 1'b1, 1'b1, 1'b0);
        vec("cin_only",     8'h00, 8'h00, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
        vec("7f_80",        8'h7F, 8'h80, 1'b0, 16'h00FF, 1'b0, 1'b1, 1'b0);
        vec("prop_ff_00_c1",8'hFF, 8'h00, 1'b1, 16'h0100, 1'b1, 1'b1, 1'b0);
        vec("msb_80_80",    8'h80, 8'h80, 1'b0, 16'h0100, 1'b1, 1'b0, 1'b1);
        vec("hi_grp_f0_10", 8'hF0, 8'h10, 1'b0, 16'h0100, 1'b1, 1'b0, 1'b1);
        vec("zero",         8'h00, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);

        // Exhaustive sweep with cin=0: sum is the plain integer sum, P is all
        // bits differing, G equals the carry out (cin is 0).
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                es = 16'(a + b);
                av = 8'(a);
                bv = 8'(b);
                vec("sweep", av, bv, 1'b0, es, es[8], &(av ^ bv), es[8]);
            end
        end

        // Register path. Load a known nonzero value first.
        @(negedge clk);
        drive(8'h03, 8'h04, 1'b0);
        @(posedge clk);
        #1;
        push_reg("reg_load_07", 16'h0007);
        -> sample_ev;

        // Asynchronous reset mid-cycle: clears with no clock edge.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        push_reg("reg_async_clear", 16'h0000);
        -> sample_ev;

        // Held in reset across an edge: stays clear.
        @(posedge clk);
        #1;
        push_reg("reg_held_reset", 16'h0000);
        -> sample_ev;

        // Release and load 0x12 + 0x34 on the first rising edge.
        @(negedge clk);
        rst_n = 1'b1;
        drive(8'h12, 8'h34, 1'b0);
        #1;
        push_reg("reg_after_release", 16'h0000);
        -> sample_ev;
        @(posedge clk);
        #1;
        push_reg("reg_12_34", 16'h0046);
        -> sample_ev;

        // Reset mid-cycle: sum_r clears at once while sum stays 0x0046.
        #3;
        rst_n = 1'b0;
        #1;
        push_reg("reg_mid_reset", 16'h0000);
        push_comb("sum_during_reset", 8'h12, 8'h34, 1'b0, 16'h0046, 1'b0, 1'b0, 1'b0);
        -> sample_ev;

        // Combinational path keeps working during reset.
        #2;
        vec("reset_ff_ff_c1", 8'hFF, 8'hFF, 1'b1, 16'h01FF, 1'b1, 1'b0, 1'b1);

        #2;
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", expq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
